// File: rtl/rr_frame_serializer.sv
// rr_frame_serializer: round-robin multi-channel frame serializer.
// Each channel offers a DATA_WIDTH word plus a bit count. A round-robin arbiter
// picks one channel while idle, and the granted frame is shifted out one bit per
// cycle on a single serial lane, optionally followed by forced idle gap cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   per-channel frame offer
//   in_ready   per-channel accept, one-hot or zero (combinational from state + in_valid)
//   in_data    channel c word at [c*DATA_WIDTH +: DATA_WIDTH]
//   in_len     channel c bit count at [c*LEN_W +: LEN_W]
//   ser_bit    serial data bit (0 when ser_valid is low)
//   ser_valid  ser_bit carries frame data this cycle
//   ser_ch     channel owning the frame on the lane (holds when idle)
//   frame_done one-cycle pulse on the last bit, or the cycle after a zero-length accept
//   busy       high while shifting or in the inter-frame gap
//   err_len    sticky flag: a frame with in_len > DATA_WIDTH was accepted
module rr_frame_serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned MSB_FIRST  = 1,
  parameter int unsigned GAP_CYCLES = 0,
  localparam int unsigned LEN_W     = $clog2(DATA_WIDTH + 1),
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH*LEN_W-1:0]      in_len,
  output logic                         ser_bit,
  output logic                         ser_valid,
  output logic [CH_W-1:0]              ser_ch,
  output logic                         frame_done,
  output logic                         busy,
  output logic                         err_len
);

  localparam int unsigned IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE0 = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t                  state_q, state_nx;

  logic [CH_W-1:0]         ptr_q, ptr_nx;
  logic [DATA_WIDTH-1:0]   data_q, data_nx;
  logic [IDX_W-1:0]        idx_q, idx_nx;
  logic [LEN_W-1:0]        rem_q, rem_nx;
  logic [GAP_W-1:0]        gap_q, gap_nx;

  logic                    ser_bit_nx, ser_valid_nx, frame_done_nx, busy_nx, err_len_nx;
  logic [CH_W-1:0]         ser_ch_nx;

  logic [CH_W-1:0]         grant_c;
  logic                    grant_vld_c;
  logic [DATA_WIDTH-1:0]   sel_data_c;
  logic [LEN_W-1:0]        sel_len_c;
  logic [LEN_W-1:0]        len_eff_c;
  logic                    len_over_c;
  logic [IDX_W-1:0]        first_idx_c;
  logic [IDX_W-1:0]        step_idx_c;
  logic [CH_W-1:0]         ptr_inc_c;

  // Round-robin arbiter: first valid channel at or after ptr, idle state only.
  always_comb begin
    int unsigned cidx;
    cidx        = 0;
    grant_c     = '0;
    grant_vld_c = 1'b0;
    in_ready    = '0;
    if (state_q == S_IDLE && rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cidx = (32'(ptr_q) + i) % NUM_CH;
        if (!grant_vld_c && in_valid[CH_W'(cidx)]) begin
          grant_c                 = CH_W'(cidx);
          grant_vld_c             = 1'b1;
          in_ready[CH_W'(cidx)]   = 1'b1;
        end
      end
    end
  end

  // Granted channel payload and clamped length.
  always_comb begin
    sel_data_c = '0;
    sel_len_c  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant_c == CH_W'(c)) begin
        sel_data_c = in_data[c*DATA_WIDTH +: DATA_WIDTH];
        sel_len_c  = in_len[c*LEN_W +: LEN_W];
      end
    end
    len_over_c = (sel_len_c > LEN_W'(DATA_WIDTH));
    len_eff_c  = len_over_c ? LEN_W'(DATA_WIDTH) : sel_len_c;
  end

  // Bit index helpers; only the len_eff LSBs of the word are ever addressed.
  always_comb begin
    first_idx_c = '0;
    step_idx_c  = idx_q;
    if (MSB_FIRST != 0) begin
      if (len_eff_c != '0) begin
        first_idx_c = IDX_W'(len_eff_c - LEN_W'(1));
      end
      if (idx_q != '0) begin
        step_idx_c = idx_q - IDX_W'(1);
      end
    end else begin
      first_idx_c = '0;
      if (idx_q != IDX_W'(DATA_WIDTH - 1)) begin
        step_idx_c = idx_q + IDX_W'(1);
      end
    end
    ptr_inc_c = (grant_c == CH_W'(NUM_CH - 1)) ? '0 : grant_c + CH_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld_c) begin
          state_nx = (len_eff_c != '0) ? S_SHIFT : S_DONE0;
        end
      end
      S_SHIFT: begin
        if (rem_q == '0) begin
          state_nx = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      S_DONE0: begin
        state_nx = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Output / datapath next values; rem counts bits still to send after the current one.
  always_comb begin
    ser_bit_nx    = 1'b0;
    ser_valid_nx  = 1'b0;
    ser_ch_nx     = ser_ch;
    frame_done_nx = 1'b0;
    busy_nx       = (state_nx == S_SHIFT) || (state_nx == S_GAP);
    err_len_nx    = err_len;
    ptr_nx        = ptr_q;
    data_nx       = data_q;
    idx_nx        = idx_q;
    rem_nx        = rem_q;
    gap_nx        = gap_q;
    case (state_q)
      S_IDLE: begin
        if (grant_vld_c) begin
          ptr_nx  = ptr_inc_c;
          data_nx = sel_data_c;
          if (len_over_c) begin
            err_len_nx = 1'b1;
          end
          if (len_eff_c != '0) begin
            idx_nx        = first_idx_c;
            ser_bit_nx    = sel_data_c[first_idx_c];
            ser_valid_nx  = 1'b1;
            ser_ch_nx     = grant_c;
            rem_nx        = len_eff_c - LEN_W'(1);
            frame_done_nx = (len_eff_c == LEN_W'(1));
          end else begin
            rem_nx        = '0;
            frame_done_nx = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (rem_q != '0) begin
          idx_nx        = step_idx_c;
          ser_bit_nx    = data_q[step_idx_c];
          ser_valid_nx  = 1'b1;
          rem_nx        = rem_q - LEN_W'(1);
          frame_done_nx = (rem_q == LEN_W'(1));
        end else begin
          gap_nx = GAP_W'(GAP_LOAD);
        end
      end
      S_DONE0: begin
        gap_nx = GAP_W'(GAP_LOAD);
      end
      S_GAP: begin
        if (gap_q != '0) begin
          gap_nx = gap_q - GAP_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ser_bit    <= 1'b0;
      ser_valid  <= 1'b0;
      ser_ch     <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      err_len    <= 1'b0;
      ptr_q      <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
    end else begin
      ser_bit    <= ser_bit_nx;
      ser_valid  <= ser_valid_nx;
      ser_ch     <= ser_ch_nx;
      frame_done <= frame_done_nx;
      busy       <= busy_nx;
      err_len    <= err_len_nx;
      ptr_q      <= ptr_nx;
      data_q     <= data_nx;
      idx_q      <= idx_nx;
      rem_q      <= rem_nx;
      gap_q      <= gap_nx;
    end
  end

endmodule

// File: tb/tb_rr_frame_serializer.sv
// Testbench for rr_frame_serializer: three instances share the input stimulus
// (a: MSB-first no gap, b: LSB-first no gap, g: MSB-first with 2 gap cycles);
// each scenario task resets all three and checks the relevant instance.
module tb_rr_frame_serializer;

  localparam int unsigned DW  = 8;
  localparam int unsigned NCH = 2;
  localparam int unsigned LW  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    in_valid = '0;
  logic [NCH*DW-1:0] in_data  = '0;
  logic [NCH*LW-1:0] in_len   = '0;

  logic [NCH-1:0] rdy_a, rdy_b, rdy_g;
  logic           bit_a, bit_b, bit_g;
  logic           vld_a, vld_b, vld_g;
  logic           ch_a, ch_b, ch_g;
  logic           done_a, done_b, done_g;
  logic           busy_a, busy_b, busy_g;
  logic           err_a, err_b, err_g;

  int errors = 0;
  int checks = 0;

  rr_frame_serializer #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MSB_FIRST(1), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_data(in_data),
    .in_len(in_len), .ser_bit(bit_a), .ser_valid(vld_a), .ser_ch(ch_a),
    .frame_done(done_a), .busy(busy_a), .err_len(err_a));

  rr_frame_serializer #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MSB_FIRST(0), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data),
    .in_len(in_len), .ser_bit(bit_b), .ser_valid(vld_b), .ser_ch(ch_b),
    .frame_done(done_b), .busy(busy_b), .err_len(err_b));

  rr_frame_serializer #(.DATA_WIDTH(DW), .NUM_CH(NCH), .MSB_FIRST(1), .GAP_CYCLES(2)) dut_g (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_g), .in_data(in_data),
    .in_len(in_len), .ser_bit(bit_g), .ser_valid(vld_g), .ser_ch(ch_g),
    .frame_done(done_g), .busy(busy_g), .err_len(err_g));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    #3;
    in_valid = 2'b11;
    rst = 1'b0;
    #1;
    checks++; if (rdy_a !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", rdy_a); end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", vld_a); end
    checks++; if (bit_a !== 1'b0) begin errors++; $display("FAIL reset_bit: got %b expected 0", bit_a); end
    checks++; if (ch_a !== 1'b0) begin errors++; $display("FAIL reset_ch: got %b expected 0", ch_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_a); end
    do_reset();
  endtask

  task automatic test_msb_frame;
    logic [7:0] word;
    word = 8'hA5;
    do_reset();
    in_data  = {8'h00, word};
    in_len   = {4'd0, 4'd8};
    in_valid = 2'b01;
    #1;
    checks++; if (rdy_a !== 2'b01) begin errors++; $display("FAIL a5_ready: got %b expected 01", rdy_a); end
    tick();
    in_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL a5_valid[%0d]: got %b expected 1", i, vld_a); end
      checks++; if (bit_a !== word[7-i]) begin errors++; $display("FAIL a5_bit[%0d]: got %b expected %b", i, bit_a, word[7-i]); end
      checks++; if (done_a !== (i == 7)) begin errors++; $display("FAIL a5_done[%0d]: got %b expected %b", i, done_a, (i == 7)); end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL a5_busy[%0d]: got %b expected 1", i, busy_a); end
      checks++; if (ch_a !== 1'b0) begin errors++; $display("FAIL a5_ch[%0d]: got %b expected 0", i, ch_a); end
      tick();
    end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL a5_valid_after: got %b expected 0", vld_a); end
    checks++; if (bit_a !== 1'b0) begin errors++; $display("FAIL a5_bit_after: got %b expected 0", bit_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL a5_done_after: got %b expected 0", done_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL a5_busy_after: got %b expected 0", busy_a); end
  endtask

  task automatic test_bit_order;
    logic [2:0] exp_msb;
    logic [2:0] exp_lsb;
    // word F6 has bits[2:0] = 110; upper ones must never appear
    exp_msb = 3'b110;
    exp_lsb = 3'b011;
    do_reset();
    in_data  = {8'h00, 8'hF6};
    in_len   = {4'd0, 4'd3};
    in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bit_a !== exp_msb[2-i]) begin errors++; $display("FAIL order_msb[%0d]: got %b expected %b", i, bit_a, exp_msb[2-i]); end
      checks++; if (bit_b !== exp_lsb[2-i]) begin errors++; $display("FAIL order_lsb[%0d]: got %b expected %b", i, bit_b, exp_lsb[2-i]); end
      checks++; if (vld_b !== 1'b1) begin errors++; $display("FAIL order_lsb_valid[%0d]: got %b expected 1", i, vld_b); end
      checks++; if (done_b !== (i == 2)) begin errors++; $display("FAIL order_lsb_done[%0d]: got %b expected %b", i, done_b, (i == 2)); end
      tick();
    end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL order_msb_end: got %b expected 0", vld_a); end
    checks++; if (vld_b !== 1'b0) begin errors++; $display("FAIL order_lsb_end: got %b expected 0", vld_b); end
  endtask

  task automatic test_round_robin;
    int sa [4];
    int ca [4];
    int ba [4];
    int sg [4];
    int cg [4];
    int exp_sa [4];
    int exp_sg [4];
    int na;
    int ng;
    logic pa;
    logic pg;
    exp_sa = '{1, 4, 7, 10};
    exp_sg = '{1, 6, 11, 16};
    for (int i = 0; i < 4; i++) begin
      sa[i] = -1; ca[i] = -1; ba[i] = -1; sg[i] = -1; cg[i] = -1;
    end
    na = 0; ng = 0; pa = 1'b0; pg = 1'b0;
    do_reset();
    // ch0 sends 01 (first bit 0), ch1 sends 10 (first bit 1)
    in_data  = {8'h02, 8'h01};
    in_len   = {4'd2, 4'd2};
    in_valid = 2'b11;
    for (int k = 1; k <= 18; k++) begin
      tick();
      if (vld_a && !pa && na < 4) begin sa[na] = k; ca[na] = int'(ch_a); ba[na] = int'(bit_a); na++; end
      if (vld_g && !pg && ng < 4) begin sg[ng] = k; cg[ng] = int'(ch_g); ng++; end
      pa = vld_a;
      pg = vld_g;
    end
    in_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      checks++; if (sa[i] !== exp_sa[i]) begin errors++; $display("FAIL rr_start[%0d]: got %0d expected %0d", i, sa[i], exp_sa[i]); end
      checks++; if (ca[i] !== i % 2) begin errors++; $display("FAIL rr_ch[%0d]: got %0d expected %0d", i, ca[i], i % 2); end
      checks++; if (ba[i] !== i % 2) begin errors++; $display("FAIL rr_firstbit[%0d]: got %0d expected %0d", i, ba[i], i % 2); end
      checks++; if (sg[i] !== exp_sg[i]) begin errors++; $display("FAIL rr_gap_start[%0d]: got %0d expected %0d", i, sg[i], exp_sg[i]); end
      checks++; if (cg[i] !== i % 2) begin errors++; $display("FAIL rr_gap_ch[%0d]: got %0d expected %0d", i, cg[i], i % 2); end
    end
  endtask

  task automatic test_len0;
    do_reset();
    in_data  = {8'hFF, 8'hFF};
    in_len   = {4'd0, 4'd0};
    in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL len0_ch0_done: got %b expected 1", done_a); end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL len0_ch0_valid: got %b expected 0", vld_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL len0_ch0_busy: got %b expected 0", busy_a); end
    tick();
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL len0_done_clear: got %b expected 0", done_a); end
    in_valid = 2'b11;
    #1;
    checks++; if (rdy_a !== 2'b10) begin errors++; $display("FAIL len0_ptr1: got %b expected 10", rdy_a); end
    tick();
    in_valid = 2'b00;
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL len0_ch1_done: got %b expected 1", done_a); end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL len0_ch1_valid: got %b expected 0", vld_a); end
    tick();
    in_valid = 2'b11;
    #1;
    checks++; if (rdy_a !== 2'b01) begin errors++; $display("FAIL len0_ptr0: got %b expected 01", rdy_a); end
    in_valid = 2'b00;
  endtask

  task automatic test_err_len;
    int nv;
    nv = 0;
    do_reset();
    in_data  = {8'h00, 8'hA5};
    in_len   = {4'd0, 4'd9};
    in_valid = 2'b01;
    #1;
    checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL err_before: got %b expected 0", err_a); end
    tick();
    in_valid = 2'b00;
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err_a); end
    for (int k = 0; k < 12; k++) begin
      if (vld_a === 1'b1) nv++;
      tick();
    end
    checks++; if (nv !== 8) begin errors++; $display("FAIL err_bitcount: got %0d expected 8", nv); end
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err_a); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] word;
    word = 8'hC3;
    do_reset();
    in_data  = {8'h00, 8'hA5};
    in_len   = {4'd8, 4'd8};
    in_valid = 2'b01;
    tick();
    in_valid = 2'b00;
    tick();
    tick();
    tick();
    checks++; if (vld_a !== 1'b1) begin errors++; $display("FAIL mid_inflight: got %b expected 1", vld_a); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", vld_a); end
    checks++; if (bit_a !== 1'b0) begin errors++; $display("FAIL mid_bit: got %b expected 0", bit_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy_a); end
    tick();
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", done_a); end
    rst = 1'b1;
    in_data  = {8'hFF, word};
    in_valid = 2'b11;
    #1;
    checks++; if (rdy_a !== 2'b01) begin errors++; $display("FAIL mid_priority: got %b expected 01", rdy_a); end
    tick();
    in_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bit_a !== word[7-i] || vld_a !== 1'b1 || ch_a !== 1'b0) begin
        errors++; $display("FAIL mid_new_bit[%0d]: got bit=%b valid=%b ch=%b expected bit=%b valid=1 ch=0", i, bit_a, vld_a, ch_a, word[7-i]);
      end
      checks++; if (done_a !== (i == 7)) begin errors++; $display("FAIL mid_new_done[%0d]: got %b expected %b", i, done_a, (i == 7)); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_msb_frame();
    test_bit_order();
    test_round_robin();
    test_len0();
    test_err_len();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
